// File: rtl/midi_voice_allocator_pkg.sv
// Shared MIDI constants, FSM encodings and message decode for the voice allocator.
package midi_voice_allocator_pkg;

  localparam int unsigned MSG_W    = 24;
  localparam int unsigned NOTE_W   = 7;
  localparam int unsigned DROP_W   = 8;

  localparam logic [3:0] NIB_NOTE_OFF     = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON      = 4'h9;
  localparam logic [3:0] NIB_CC           = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_NOTE_ON  = 2'd1,
    CMD_NOTE_OFF = 2'd2,
    CMD_ALL_OFF  = 2'd3
  } cmd_e;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_msg_t;

  // Classify a channel-accepted message; Note On with velocity 0 is a Note Off.
  function automatic cmd_e decode_cmd(input midi_msg_t m);
    cmd_e cmd;
    cmd = CMD_NONE;
    case (m.status[7:4])
      NIB_NOTE_ON:  cmd = (m.data2[6:0] != 7'd0) ? CMD_NOTE_ON : CMD_NOTE_OFF;
      NIB_NOTE_OFF: cmd = CMD_NOTE_OFF;
      NIB_CC:       if (m.data1[6:0] == CC_ALL_NOTES_OFF) cmd = CMD_ALL_OFF;
      default:      cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/midi_voice_lru.sv
// Least-recently-allocated ranking of voices; rank 0 is newest, NUM_VOICES-1 oldest.
module midi_voice_lru
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] oldest_idx
);

  logic [IDX_W-1:0] rank_q [NUM_VOICES];

  // Touched voice becomes newest; voices that were newer than it age by one.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= IDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          rank_q[i] <= '0;
        end else if (rank_q[i] < rank_q[touch_idx]) begin
          rank_q[i] <= rank_q[i] + IDX_W'(1);
        end
      end
    end
  end

  // Locate the voice holding the oldest rank.
  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rank_q[i] == IDX_W'(NUM_VOICES - 1)) oldest_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Maps channel-filtered MIDI Note On/Off onto a fixed voice pool with retrigger/free/steal policy.
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned CHANNEL    = 0,
  parameter bit          OMNI       = 1'b0
) (
  input  logic                         clock,
  input  logic                         clr_n,
  input  logic                         msg_valid,
  input  logic [MSG_W-1:0]             msg_bytes,
  output logic                         msg_ready,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_vel,
  output logic                         voice_update,
  output logic [IDX_W-1:0]             voice_update_idx,
  output logic [DROP_W-1:0]            drop_count
);

  state_e                state_q;
  cmd_e                  cmd_q;
  midi_msg_t             msg_q;
  logic                  ready_q;
  logic [NUM_VOICES-1:0] gate_q;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     vel_q  [NUM_VOICES];
  logic                  upd_q;
  logic [IDX_W-1:0]      upd_idx_q;
  logic [DROP_W-1:0]     drop_q;
  logic [IDX_W-1:0]      scan_idx_q;
  logic [IDX_W-1:0]      hit_idx_q;
  logic [IDX_W-1:0]      free_idx_q;
  logic                  hit_found_q;
  logic                  free_found_q;

  logic                  chan_ok_c;
  cmd_e                  dec_cmd_c;
  logic [IDX_W-1:0]      oldest_idx_c;
  logic [IDX_W-1:0]      target_idx_c;
  logic                  touch_c;
  logic                  unused_msg_bits;

  // Data bytes carry 7-bit payloads; the top bit is a don't-care.
  assign unused_msg_bits = ^{msg_q.data1[7], msg_q.data2[7]};

  // Channel filter, command decode and Note On target selection.
  always_comb begin
    chan_ok_c    = OMNI || (msg_q.status[3:0] == 4'(CHANNEL));
    dec_cmd_c    = chan_ok_c ? decode_cmd(msg_q) : CMD_NONE;
    target_idx_c = hit_found_q ? hit_idx_q : (free_found_q ? free_idx_q : oldest_idx_c);
    touch_c      = (state_q == ST_COMMIT) && (cmd_q == CMD_NOTE_ON);
  end

  midi_voice_lru #(
    .NUM_VOICES(NUM_VOICES),
    .IDX_W     (IDX_W)
  ) u_lru (
    .clock     (clock),
    .clr_n     (clr_n),
    .touch     (touch_c),
    .touch_idx (target_idx_c),
    .oldest_idx(oldest_idx_c)
  );

  // Message FSM with registered voice bank, handshake and drop counter.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_NONE;
      msg_q        <= '0;
      ready_q      <= 1'b1;
      gate_q       <= '0;
      upd_q        <= 1'b0;
      upd_idx_q    <= '0;
      drop_q       <= '0;
      scan_idx_q   <= '0;
      hit_idx_q    <= '0;
      free_idx_q   <= '0;
      hit_found_q  <= 1'b0;
      free_found_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
    end else begin
      upd_q <= 1'b0;
      if (msg_valid && !ready_q && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (msg_valid) begin
            msg_q   <= msg_bytes;
            ready_q <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          scan_idx_q   <= '0;
          hit_found_q  <= 1'b0;
          free_found_q <= 1'b0;
          cmd_q        <= dec_cmd_c;
          if ((dec_cmd_c == CMD_NOTE_ON) || (dec_cmd_c == CMD_NOTE_OFF)) begin
            state_q <= ST_SCAN;
          end else begin
            if (dec_cmd_c == CMD_ALL_OFF) gate_q <= '0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (gate_q[scan_idx_q] && (note_q[scan_idx_q] == msg_q.data1[6:0]) && !hit_found_q) begin
            hit_found_q <= 1'b1;
            hit_idx_q   <= scan_idx_q;
          end
          if (!gate_q[scan_idx_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_idx_q;
          end
          if (scan_idx_q == IDX_W'(NUM_VOICES - 1)) state_q <= ST_COMMIT;
          else scan_idx_q <= scan_idx_q + IDX_W'(1);
        end
        ST_COMMIT: begin
          if (cmd_q == CMD_NOTE_ON) begin
            gate_q[target_idx_c] <= 1'b1;
            note_q[target_idx_c] <= msg_q.data1[6:0];
            vel_q[target_idx_c]  <= msg_q.data2[6:0];
            upd_q                <= 1'b1;
            upd_idx_q            <= target_idx_c;
          end else if (hit_found_q) begin
            gate_q[hit_idx_q] <= 1'b0;
            upd_q             <= 1'b1;
            upd_idx_q         <= hit_idx_q;
          end
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Pack per-voice registers onto the flat output buses.
  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[NOTE_W*i +: NOTE_W] = note_q[i];
      voice_vel[NOTE_W*i +: NOTE_W]  = vel_q[i];
    end
  end

  assign msg_ready        = ready_q;
  assign voice_gate       = gate_q;
  assign voice_update     = upd_q;
  assign voice_update_idx = upd_idx_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed self-checking bench for midi_voice_allocator at the default 4-voice configuration.
module tb_midi_voice_allocator;

  localparam int unsigned NV = 4;

  logic          clock = 1'b0;
  logic          clr_n;
  logic          msg_valid;
  logic [23:0]   msg_bytes;
  logic          msg_ready;
  logic [NV-1:0] voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_vel;
  logic          voice_update;
  logic [1:0]    voice_update_idx;
  logic [7:0]    drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int lat;
  int snap;

  midi_voice_allocator #(
    .NUM_VOICES(NV),
    .IDX_W     (2),
    .CHANNEL   (0),
    .OMNI      (1'b0)
  ) dut (
    .clock           (clock),
    .clr_n           (clr_n),
    .msg_valid       (msg_valid),
    .msg_bytes       (msg_bytes),
    .msg_ready       (msg_ready),
    .voice_gate      (voice_gate),
    .voice_note      (voice_note),
    .voice_vel       (voice_vel),
    .voice_update    (voice_update),
    .voice_update_idx(voice_update_idx),
    .drop_count      (drop_count)
  );

  always #5 clock = ~clock;

  // Count voice_update pulses (one sample per cycle, mid-period).
  always @(negedge clock) if (voice_update) upd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; land just after the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    clr_n     = 1'b0;
    msg_valid = 1'b0;
    msg_bytes = '0;
    step();
    step();
    clr_n = 1'b1;
    step();
  endtask

  // Present one message and return cycles from accept edge to msg_ready high.
  task automatic send(input logic [23:0] b, output int n);
    msg_bytes = b;
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    n = 0;
    while (!msg_ready && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    clr_n     = 1'b0;
    msg_valid = 1'b0;
    msg_bytes = '0;
    do_reset();

    // Reset state
    check_eq("rst_ready", 32'(msg_ready), 32'd1);
    check_eq("rst_gate", 32'(voice_gate), 32'd0);
    check_eq("rst_note", 32'(voice_note), 32'd0);
    check_eq("rst_vel", 32'(voice_vel), 32'd0);
    check_eq("rst_upd", 32'(voice_update), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);

    // Single Note On
    send(24'h903C64, lat);
    check_eq("on_lat", 32'(lat), 32'd6);
    check_eq("on_upd", 32'(voice_update), 32'd1);
    check_eq("on_idx", 32'(voice_update_idx), 32'd0);
    check_eq("on_gate", 32'(voice_gate), 32'b0001);
    check_eq("on_note", 32'(voice_note), 32'd60);
    check_eq("on_vel", 32'(voice_vel), 32'd100);

    // Fill pool, then steal oldest twice
    do_reset();
    send(24'h903C64, lat);
    send(24'h903E64, lat);
    send(24'h904064, lat);
    send(24'h904164, lat);
    check_eq("fill_gate", 32'(voice_gate), 32'b1111);
    check_eq("fill_notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd60}));
    send(24'h904350, lat);
    check_eq("steal_lat", 32'(lat), 32'd6);
    check_eq("steal_idx", 32'(voice_update_idx), 32'd0);
    check_eq("steal_notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd67}));
    check_eq("steal_vel", 32'(voice_vel), 32'({7'd100, 7'd100, 7'd100, 7'd80}));
    send(24'h904564, lat);
    check_eq("steal2_idx", 32'(voice_update_idx), 32'd1);
    check_eq("steal2_notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd69, 7'd67}));

    // Note On vel 0 releases; unmatched Note Off changes nothing
    do_reset();
    send(24'h903C64, lat);
    step();
    snap = upd_cnt;
    send(24'h903C00, lat);
    step();
    check_eq("off_gate", 32'(voice_gate), 32'd0);
    check_eq("off_note", 32'(voice_note), 32'd60);
    check_eq("off_vel", 32'(voice_vel), 32'd100);
    check_eq("off_idx", 32'(voice_update_idx), 32'd0);
    check_eq("off_pulses", 32'(upd_cnt - snap), 32'd1);
    snap = upd_cnt;
    send(24'h804000, lat);
    step();
    check_eq("miss_lat", 32'(lat), 32'd6);
    check_eq("miss_pulses", 32'(upd_cnt - snap), 32'd0);

    // Retrigger same note on the same voice
    do_reset();
    send(24'h903C64, lat);
    send(24'h903C14, lat);
    check_eq("retrig_idx", 32'(voice_update_idx), 32'd0);
    check_eq("retrig_gate", 32'(voice_gate), 32'b0001);
    check_eq("retrig_vel", 32'(voice_vel), 32'd20);

    // Channel filter, non-status byte, all-notes-off
    do_reset();
    snap = upd_cnt;
    send(24'h913C64, lat);
    check_eq("chan_lat", 32'(lat), 32'd1);
    check_eq("chan_gate", 32'(voice_gate), 32'd0);
    send(24'h103C64, lat);
    check_eq("data_lat", 32'(lat), 32'd1);
    step();
    check_eq("filt_pulses", 32'(upd_cnt - snap), 32'd0);
    send(24'h903C64, lat);
    send(24'h903E64, lat);
    send(24'h904064, lat);
    check_eq("ano_pre_gate", 32'(voice_gate), 32'b0111);
    step();
    snap = upd_cnt;
    send(24'hB07B00, lat);
    check_eq("ano_lat", 32'(lat), 32'd1);
    check_eq("ano_gate", 32'(voice_gate), 32'd0);
    step();
    check_eq("ano_pulses", 32'(upd_cnt - snap), 32'd0);

    // Strobe while busy is dropped; first message still commits
    do_reset();
    msg_bytes = 24'h903C64;
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    step();
    msg_bytes = 24'h903E64;
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    lat = 0;
    while (!msg_ready && lat < 40) begin
      step();
      lat++;
    end
    check_eq("drop_wait", 32'(msg_ready), 32'd1);
    check_eq("drop_count", 32'(drop_count), 32'd1);
    check_eq("drop_gate", 32'(voice_gate), 32'b0001);
    check_eq("drop_note", 32'(voice_note), 32'd60);

    // Asynchronous reset while scanning
    msg_bytes = 24'h904064;
    msg_valid = 1'b1;
    step();
    msg_valid = 1'b0;
    step();
    step();
    clr_n = 1'b0;
    #1;
    check_eq("clr_ready", 32'(msg_ready), 32'd1);
    check_eq("clr_gate", 32'(voice_gate), 32'd0);
    check_eq("clr_note", 32'(voice_note), 32'd0);
    check_eq("clr_drop", 32'(drop_count), 32'd0);
    step();
    clr_n = 1'b1;
    step();
    send(24'h903E30, lat);
    check_eq("recov_lat", 32'(lat), 32'd6);
    check_eq("recov_idx", 32'(voice_update_idx), 32'd0);
    check_eq("recov_note", 32'(voice_note), 32'd62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
